dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the CPU data-memory request interface.
//  - Accepts one load/store request at a time from the pipeline MEM stage.
//  - Services it from an internal word array after a fixed, parameterised latency.
//  - Returns read data and an error flag, and drives busy so the pipeline can stall.
//  - Replaces the single-cycle dmem for multi-cycle memory experiments.
// PARAMETERS
//  DMEM_DEPTH       1024  number of 32-bit words in the array
//  DMEM_ADDR_WIDTH  10    log2(DMEM_DEPTH); word-index width
//  LATENCY          2     cycles from request accept to rsp_valid; legal range 1..15
// PORTS
//  clk         in   1   system clock; all state updates on posedge
//  reset_b     in   1   asynchronous reset, active-HIGH (1 = reset, despite the _b suffix)
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request
//  req_write   in   1   1 = store, 0 = load
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data
//  req_wstrb   in   4   byte-enable for stores; bit i enables wdata[8i+7:8i]
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   requester accepts the response
//  rsp_rdata   out  32  load data; 0 for stores and errored requests
//  rsp_err     out  1   request was misaligned or out of range
//  busy        out  1   transaction in flight; the pipeline stalls MEM while high
// BEHAVIOUR
//  Reset (async, reset_b=1):
//  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, cnt=0.
//  - Array contents are NOT reset.
//  FSM: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE:
//  - req_ready=1.
//  - On req_valid && req_ready at edge T: latch write/addr/wdata/wstrb, load cnt=LATENCY-1, go BUSY.
//  BUSY (req_ready=0):
//  - If cnt != 0: cnt <= cnt-1.
//  - If cnt == 0: commit the access and go RESP.
//  - Result: rsp_valid is first high after edge T+LATENCY.
//  Commit (BUSY->RESP edge):
//  - err = (addr[1:0] != 0) || (addr[31:DMEM_ADDR_WIDTH+2] != 0).
//  - err=1: no array update, rsp_rdata=0, rsp_err=1.
//  - Load: rsp_rdata = mem[addr[DMEM_ADDR_WIDTH+1:2]].
//  - Store: each strobed byte of that word is updated; rsp_rdata=0. wstrb=0 is a legal no-op with rsp_err=0.
//  RESP (req_ready=0):
//  - rsp_valid=1; rsp_rdata and rsp_err are held stable until handshake.
//  - On rsp_valid && rsp_ready: go IDLE; rsp_valid=0 from the next cycle.
//  Signal rules:
//  - rsp_rdata and rsp_err keep their last values in IDLE.
//  - busy = (state != IDLE), combinational from state.
//  - All req_* inputs are ignored while req_ready=0. There is no pipelining and no queueing.
//  - Minimum spacing between accepts is LATENCY+2 cycles when rsp_ready is held at 1.
//  - wstrb is ignored on loads.
//  Reset mid-operation:
//  - Aborts the transaction. A store whose commit edge has not occurred is never written.
//  - The pending response is discarded and the outputs return to reset values.
//  Widths:
//  - cnt is 4 bits.
//  - Byte address decodes to word index addr[DMEM_ADDR_WIDTH+1:2].
//  - No wrap-around: out-of-range addresses error rather than alias.
// TESTING
//  1. Reset, then store addr=0x10 wdata=0xDEADBEEF wstrb=4'hF, then load 0x10, LATENCY=2:
//     rsp_rdata=0xDEADBEEF, rsp_err=0; each rsp_valid rises exactly 2 edges after its accept.
//  2. Word at 0x10 = 0x11223344; store wdata=0xAABBCCDD wstrb=4'b0101; load 0x10:
//     rsp_rdata=0x11BB33DD.
//  3. Load addr=0x12 (misaligned), then store addr=0x1000 (beyond 1024 words):
//     both give rsp_err=1, rsp_rdata=0; array contents are unchanged.
//  4. Hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid and req_addr:
//     rsp_valid/rdata stable, req_ready=0, busy=1, no extra accept; IDLE one cycle after rsp_ready=1.
//  5. Accept store 0x20=0x55 with LATENCY=3, assert reset_b one cycle after accept, release, load 0x20:
//     old value returned; rsp_valid=0 and busy=0 during reset.
//  6. LATENCY=1, back-to-back requests with rsp_ready=1:
//     accepts are exactly 3 cycles apart; rsp_valid is high one cycle per transaction.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle responder for the CPU data-memory request interface.
// One request in flight; fixed LATENCY from accept to response; misaligned or out-of-range accesses error.
module dmem_responder #(
    parameter int DMEM_DEPTH      = 1024,
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int LATENCY         = 2
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [DMEM_DEPTH];

    logic                       w_accept;
    logic                       w_commit;
    logic                       w_rsp_hs;
    logic                       w_err;
    logic [DMEM_ADDR_WIDTH-1:0] w_idx;
    logic [31:0]                w_rd_word;

    // Out-of-range addresses error instead of aliasing onto low words.
    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) ||
               (a[31:DMEM_ADDR_WIDTH+2] != {(30-DMEM_ADDR_WIDTH){1'b0}});
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign w_accept  = (r_state == S_IDLE) && req_valid;
    assign w_commit  = (r_state == S_BUSY) && (r_cnt == 4'd0);
    assign w_rsp_hs  = (r_state == S_RESP) && rsp_ready;
    assign w_err     = addr_err(r_addr);
    assign w_idx     = r_addr[DMEM_ADDR_WIDTH+1:2];
    assign w_rd_word = r_mem[w_idx];

    // State register.
    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) w_state_nxt = S_BUSY;
                else           w_state_nxt = S_IDLE;
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) w_state_nxt = S_RESP;
                else               w_state_nxt = S_BUSY;
            end
            S_RESP: begin
                if (rsp_ready) w_state_nxt = S_IDLE;
                else           w_state_nxt = S_RESP;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch, latency counter and registered response outputs.
    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write     <= req_write;
                r_addr      <= req_addr;
                r_wdata     <= req_wdata;
                r_wstrb     <= req_wstrb;
                r_cnt       <= 4'(LATENCY - 1);
                r_req_ready <= 1'b0;
            end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || r_write) ? 32'd0 : w_rd_word;
            end
            if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
                r_req_ready <= 1'b1;
            end
        end
    end

    // Array write; contents survive reset, and an aborted store never reaches its commit edge.
    always_ff @(posedge clk) begin
        if (w_commit && r_write && !w_err) begin
            r_mem[w_idx] <= byte_merge(w_rd_word, r_wdata, r_wstrb);
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LATENCY 2, 3, 1) share stimulus;
// the idle ones are held in reset while a monitor checks the selected one.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst = 3'b111;
    logic [1:0]  sel = 2'd0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wstrb = 4'd0;
    logic        rsp_ready = 1'b1;

    logic [2:0]  rq_rdy, rv, re, bz;
    logic [31:0] rd [3];

    logic        m_rdy, m_rv, m_re, m_bz;
    logic [31:0] m_rd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_acc  = 0;
    int vcyc   = 0;
    exp_t exp_q [$];
    int   acc_q [$];
    int   acc_hist [$];

    dmem_responder #(.DMEM_DEPTH(1024), .DMEM_ADDR_WIDTH(10), .LATENCY(2)) u_l2 (
        .clk(clk), .reset_b(rst[0]), .req_valid(req_valid), .req_ready(rq_rdy[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd[0]), .rsp_err(re[0]), .busy(bz[0]));

    dmem_responder #(.DMEM_DEPTH(1024), .DMEM_ADDR_WIDTH(10), .LATENCY(3)) u_l3 (
        .clk(clk), .reset_b(rst[1]), .req_valid(req_valid), .req_ready(rq_rdy[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd[1]), .rsp_err(re[1]), .busy(bz[1]));

    dmem_responder #(.DMEM_DEPTH(1024), .DMEM_ADDR_WIDTH(10), .LATENCY(1)) u_l1 (
        .clk(clk), .reset_b(rst[2]), .req_valid(req_valid), .req_ready(rq_rdy[2]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rv[2]), .rsp_ready(rsp_ready), .rsp_rdata(rd[2]), .rsp_err(re[2]), .busy(bz[2]));

    assign m_rdy = rq_rdy[sel];
    assign m_rv  = rv[sel];
    assign m_re  = re[sel];
    assign m_bz  = bz[sel];
    assign m_rd  = rd[sel];

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic int lat_of(input logic [1:0] s);
        case (s)
            2'd0:    return 2;
            2'd1:    return 3;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: accept times, response latency and scoreboard comparison at each handshake.
    initial begin
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst[sel]) begin
                if (m_rdy && req_valid) begin
                    acc_q.push_back(cyc + 1);
                    acc_hist.push_back(cyc + 1);
                    n_acc = n_acc + 1;
                end
                if (m_rv) vcyc = vcyc + 1;
                if (m_rv && !prev_v) begin
                    if (acc_q.size() == 0) chk("latency_no_accept", 32'd1, 32'd0);
                    else chk("rsp_latency", 32'(cyc), 32'(acc_q.pop_front() + lat_of(sel)));
                end
                if (m_rv && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("rsp_rdata", m_rd, e.rdata);
                        chk("rsp_err", {31'd0, m_re}, {31'd0, e.err});
                    end
                end
                prev_v = m_rv;
            end else begin
                prev_v = 1'b0;
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] er, input logic ee);
        int n;
        exp_t e;
        n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = ws;
        @(negedge clk);
        while (!m_rdy && n < 50) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= 50) begin
            chk("accept_timeout", 32'd1, 32'd0);
        end else begin
            e.rdata = er;
            e.err   = ee;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !m_rdy) && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= 100) chk("rsp_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=done", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int acc_before;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", {31'd0, m_rv}, 32'd0);
        chk("reset_req_ready", {31'd0, m_rdy}, 32'd1);
        chk("reset_busy", {31'd0, m_bz}, 32'd0);
        chk("reset_rdata", m_rd, 32'd0);
        chk("reset_err", {31'd0, m_re}, 32'd0);
        @(posedge clk); #1; rst[0] = 1'b0;

        // Full-word store then load
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0); wait_idle();
        issue(1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0); wait_idle();

        // Byte-strobed store, then a wstrb=0 no-op store
        issue(1'b1, 32'h10, 32'h11223344, 4'hF, 32'd0, 1'b0); wait_idle();
        issue(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 32'd0, 1'b0); wait_idle();
        issue(1'b0, 32'h10, 32'hFFFFFFFF, 4'hF, 32'h11BB33DD, 1'b0); wait_idle();
        issue(1'b1, 32'h10, 32'h99999999, 4'h0, 32'd0, 1'b0); wait_idle();
        issue(1'b0, 32'h10, 32'd0, 4'h0, 32'h11BB33DD, 1'b0); wait_idle();

        // Error cases leave the array untouched
        issue(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0); wait_idle();
        issue(1'b0, 32'h12, 32'd0, 4'h0, 32'd0, 1'b1); wait_idle();
        issue(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1); wait_idle();
        issue(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1); wait_idle();
        issue(1'b0, 32'hFFFFFFFC, 32'd0, 4'h0, 32'd0, 1'b1); wait_idle();
        issue(1'b0, 32'h0, 32'd0, 4'h0, 32'hCAFEF00D, 1'b0); wait_idle();
        issue(1'b0, 32'h10, 32'd0, 4'h0, 32'h11BB33DD, 1'b0); wait_idle();

        // Response back-pressure with junk on the request side
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'd0, 4'h0, 32'h11BB33DD, 1'b0);
        for (int i = 0; i < 20 && !m_rv; i++) @(negedge clk);
        acc_before = n_acc;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            req_valid = ~req_valid;
            req_write = 1'b1;
            req_addr  = 32'h40 + 32'(i * 4);
            @(negedge clk);
            chk("hold_rsp_valid", {31'd0, m_rv}, 32'd1);
            chk("hold_rdata", m_rd, 32'h11BB33DD);
            chk("hold_req_ready", {31'd0, m_rdy}, 32'd0);
            chk("hold_busy", {31'd0, m_bz}, 32'd1);
        end
        chk("hold_no_accept", 32'(n_acc), 32'(acc_before));
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_hs_rsp_valid", {31'd0, m_rv}, 32'd0);
        chk("post_hs_req_ready", {31'd0, m_rdy}, 32'd1);
        chk("post_hs_busy", {31'd0, m_bz}, 32'd0);
        chk("post_hs_sb_empty", 32'(exp_q.size()), 32'd0);

        // LATENCY=3: reset aborts an accepted store
        @(posedge clk); #1; rst[0] = 1'b1; sel = 2'd1; rst[1] = 1'b0;
        issue(1'b1, 32'h20, 32'h12345678, 4'hF, 32'd0, 1'b0); wait_idle();
        issue(1'b0, 32'h20, 32'd0, 4'h0, 32'h12345678, 1'b0); wait_idle();
        @(negedge clk);
        chk("idle_rdata_held", m_rd, 32'h12345678);
        issue(1'b1, 32'h20, 32'h00000055, 4'hF, 32'd0, 1'b0);
        @(posedge clk); #1; rst[1] = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_valid", {31'd0, m_rv}, 32'd0);
        chk("midrst_busy", {31'd0, m_bz}, 32'd0);
        chk("midrst_req_ready", {31'd0, m_rdy}, 32'd1);
        chk("midrst_rdata", m_rd, 32'd0);
        exp_q.delete();
        acc_q.delete();
        repeat (3) @(posedge clk);
        #1; rst[1] = 1'b0;
        issue(1'b0, 32'h20, 32'd0, 4'h0, 32'h12345678, 1'b0); wait_idle();

        // LATENCY=1: back-to-back accepts
        @(posedge clk); #1; rst[1] = 1'b1; sel = 2'd2; rst[2] = 1'b0;
        @(negedge clk);
        acc_hist.delete();
        vcyc = 0;
        issue(1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, 32'd0, 1'b0);
        issue(1'b0, 32'h8, 32'd0, 4'h0, 32'hA5A5A5A5, 1'b0);
        issue(1'b1, 32'hC, 32'h5A5A0000, 4'hC, 32'd0, 1'b0);
        issue(1'b0, 32'h8, 32'd0, 4'h0, 32'hA5A5A5A5, 1'b0);
        wait_idle();
        chk("b2b_accepts", 32'(acc_hist.size()), 32'd4);
        for (int i = 1; i < acc_hist.size(); i++) begin
            chk("b2b_spacing", 32'(acc_hist[i] - acc_hist[i-1]), 32'd3);
        end
        chk("b2b_valid_cycles", 32'(vcyc), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
